// File: rtl/dct_row_packer.sv
// Input stage of the 2D DCT: level-shifts unsigned pixels, packs 16 samples
// into one row word and tracks row position within a 16x16 block.
module dct_row_packer #(
    parameter int unsigned BW  = 11,
    parameter int unsigned PW  = 8,
    parameter int unsigned GAP = 0
) (
    input  logic               i_clk,
    input  logic               i_Reset,
    input  logic [PW-1:0]      i_pixel,
    input  logic               i_valid,
    output logic               o_ready,
    output logic [16*BW-1:0]   o_data,
    output logic               o_en,
    output logic [3:0]         o_row,
    output logic               o_last
);

    localparam int unsigned DW = 16 * BW;
    localparam int unsigned CW = (GAP > 1) ? $clog2(GAP + 1) : 1;

    typedef enum logic {
        FILL,
        GAPWAIT
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   gap_cnt, gap_cnt_nxt;
    logic [3:0]      col, row;
    logic [BW-1:0]   pack [16];
    logic [BW-1:0]   elem;
    logic [DW-1:0]   row_word;
    logic            accept, row_done;

    // Level shift: flipping the MSB subtracts 2^(PW-1); the flipped MSB is the sign.
    if (BW > PW) begin : g_ext
        assign elem = {{(BW-PW){~i_pixel[PW-1]}}, ~i_pixel[PW-1], i_pixel[PW-2:0]};
    end else begin : g_noext
        assign elem = {~i_pixel[PW-1], i_pixel[PW-2:0]};
    end

    assign o_ready  = (state == FILL) && !i_Reset;
    assign accept   = i_valid && o_ready;
    assign row_done = accept && (col == 4'd15);

    // Completed row: slots 0..14 from the packing register, slot 15 straight from the input.
    always_comb begin
        row_word = '0;
        for (int i = 0; i < 15; i++) begin
            row_word[(15-i)*BW +: BW] = pack[i];
        end
        row_word[BW-1:0] = elem;
    end

    always_comb begin
        state_nxt   = state;
        gap_cnt_nxt = gap_cnt;
        case (state)
            FILL: begin
                if (GAP > 0 && row_done && row == 4'd15) begin
                    state_nxt   = GAPWAIT;
                    gap_cnt_nxt = CW'(GAP);
                end
            end
            GAPWAIT: begin
                if (gap_cnt == CW'(1)) begin
                    state_nxt = FILL;
                end else begin
                    gap_cnt_nxt = gap_cnt - CW'(1);
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_Reset) begin
            state   <= FILL;
            gap_cnt <= '0;
            col     <= '0;
            row     <= '0;
            o_data  <= '0;
            o_en    <= 1'b0;
            o_row   <= '0;
            o_last  <= 1'b0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_cnt_nxt;
            o_en    <= row_done;
            o_last  <= row_done && (row == 4'd15);
            if (accept) begin
                col <= col + 4'd1;
            end
            if (row_done) begin
                o_data <= row_word;
                o_row  <= row;
                row    <= row + 4'd1;
            end
        end
    end

    // Packing register is pure datapath; partial rows are discarded by clearing col.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            pack[col] <= elem;
        end
    end

endmodule

// File: tb/tb_dct_row_packer.sv
// Scoreboard bench for dct_row_packer (BW=11, PW=8, GAP=16).
module tb_dct_row_packer;

    localparam int unsigned BW  = 11;
    localparam int unsigned PW  = 8;
    localparam int unsigned GAP = 16;
    localparam int unsigned DW  = 16 * BW;

    typedef struct {
        logic [DW-1:0] data;
        logic [3:0]    row;
        logic          last;
        int            cyc;
    } exp_t;

    logic            i_clk;
    logic            i_Reset;
    logic [PW-1:0]   i_pixel;
    logic            i_valid;
    logic            o_ready;
    logic [DW-1:0]   o_data;
    logic            o_en;
    logic [3:0]      o_row;
    logic            o_last;

    exp_t            sb[$];
    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;
    int              en_cnt = 0;
    int              last_cnt = 0;
    logic            prev_en = 1'b0;
    logic            acc;
    int              m_col = 0;
    logic [3:0]      m_row = '0;
    logic [DW-1:0]   m_word = '0;
    logic [DW-1:0]   m_last = '0;

    dct_row_packer #(.BW(BW), .PW(PW), .GAP(GAP)) dut (
        .i_clk  (i_clk),
        .i_Reset(i_Reset),
        .i_pixel(i_pixel),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .o_data (o_data),
        .o_en   (o_en),
        .o_row  (o_row),
        .o_last (o_last)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] lvl(input logic [PW-1:0] p);
        int s;
        s = int'(p) - (1 << (PW - 1));
        return BW'(s);
    endfunction

    // Drive one cycle of stimulus and advance the reference model on an accept.
    task automatic step(input logic rst, input logic v, input logic [PW-1:0] pix);
        exp_t e;
        @(negedge i_clk);
        i_Reset = rst;
        i_valid = v;
        i_pixel = pix;
        #1;
        acc = v && (o_ready === 1'b1) && !rst;
        if (rst) begin
            m_col = 0;
            m_row = '0;
            m_word = '0;
        end else if (acc) begin
            m_word[(15-m_col)*BW +: BW] = lvl(pix);
            if (m_col == 15) begin
                e.data = m_word;
                e.row  = m_row;
                e.last = (m_row == 4'd15);
                e.cyc  = cyc + 1;
                sb.push_back(e);
                m_last = m_word;
                m_row  = m_row + 4'd1;
                m_col  = 0;
            end else begin
                m_col++;
            end
        end
    endtask

    // Output monitor: every row pulse is matched against the scoreboard.
    always @(negedge i_clk) begin
        exp_t e;
        if (o_en === 1'b1) begin
            en_cnt++;
            if (o_last === 1'b1) last_cnt++;
            if (prev_en) chk("en_back_to_back", DW'(1), DW'(0));
            if (sb.size() == 0) begin
                chk("unexpected_en", DW'(1), DW'(0));
            end else begin
                e = sb.pop_front();
                chk("row_data", o_data, e.data);
                chk("row_idx", DW'(o_row), DW'(e.row));
                chk("row_last", DW'(o_last), DW'(e.last));
                chk("row_latency", DW'(cyc), DW'(e.cyc));
            end
        end else if (o_last === 1'b1) begin
            chk("last_without_en", DW'(1), DW'(0));
        end
        prev_en = (o_en === 1'b1);
    end

    initial begin
        logic [PW-1:0] pat [4];
        logic [BW-1:0] pat_exp [4];
        int n, guard, e0, l0, gl;
        logic first;

        pat[0] = 8'd255; pat[1] = 8'd128; pat[2] = 8'd127; pat[3] = 8'd0;
        pat_exp[0] = 11'h07F; pat_exp[1] = 11'h000; pat_exp[2] = 11'h7FF; pat_exp[3] = 11'h780;
        i_Reset = 1'b1;
        i_valid = 1'b0;
        i_pixel = '0;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'($urandom), PW'($urandom));
            chk("rst_ready", DW'(o_ready), DW'(0));
            if (i > 0) begin
                chk("rst_en", DW'(o_en), DW'(0));
                chk("rst_data", o_data, '0);
                chk("rst_row", DW'(o_row), DW'(0));
                chk("rst_last", DW'(o_last), DW'(0));
            end
        end
        step(1'b0, 1'b0, '0);
        chk("ready_after_release", DW'(o_ready), DW'(1));

        // Continuous ramp 0..15
        for (int p = 0; p < 16; p++) step(1'b0, 1'b1, PW'(p));
        step(1'b0, 1'b0, '0);
        chk("ramp_en", DW'(o_en), DW'(1));
        chk("ramp_slot0", DW'(o_data[DW-1 -: BW]), DW'(11'h780));
        chk("ramp_slot15", DW'(o_data[BW-1:0]), DW'(11'h78F));
        chk("ramp_row", DW'(o_row), DW'(0));
        chk("ramp_last", DW'(o_last), DW'(0));

        // Extremes with random valid holes
        e0 = en_cnt;
        n = 0;
        guard = 0;
        while (n < 16 && guard < 300) begin
            step(1'b0, 1'($urandom), pat[n % 4]);
            if (acc) n++;
            guard++;
        end
        chk("holes_done", DW'(n), DW'(16));
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        chk("holes_one_en", DW'(en_cnt - e0), DW'(1));
        for (int j = 0; j < 16; j++)
            chk("holes_slice", DW'(o_data[(15-j)*BW +: BW]), DW'(pat_exp[j % 4]));

        // Full block with gap, starting from a fresh block
        step(1'b1, 1'b0, '0);
        e0 = en_cnt;
        l0 = last_cnt;
        for (int i = 0; i < 256; i++) step(1'b0, 1'b1, PW'($urandom));
        gl = 0;
        first = 1'b1;
        while (gl < 100) begin
            step(1'b0, 1'b1, PW'($urandom));
            if (first) begin
                chk("gap_first_en", DW'(o_en), DW'(1));
                chk("gap_first_last", DW'(o_last), DW'(1));
                first = 1'b0;
            end
            if (o_ready === 1'b1) break;
            gl++;
        end
        chk("gap_len", DW'(gl), DW'(GAP));
        chk("block_en", DW'(en_cnt - e0), DW'(16));
        chk("block_last", DW'(last_cnt - l0), DW'(1));
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, PW'($urandom));
        step(1'b0, 1'b0, '0);
        chk("post_gap_en", DW'(o_en), DW'(1));
        chk("post_gap_row", DW'(o_row), DW'(0));

        // Mid-row reset discards the partial row
        e0 = en_cnt;
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, PW'($urandom));
        step(1'b1, 1'b1, PW'($urandom));
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, PW'($urandom));
        step(1'b0, 1'b0, '0);
        chk("midrst_en", DW'(o_en), DW'(1));
        chk("midrst_row", DW'(o_row), DW'(0));
        chk("midrst_en_count", DW'(en_cnt - e0), DW'(1));

        // Idle hold
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 1'b0, PW'($urandom));
            chk("hold_data", o_data, m_last);
            chk("hold_en", DW'(o_en), DW'(0));
        end

        step(1'b0, 1'b0, '0);
        chk("sb_empty", DW'(sb.size()), DW'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dct_row_packer.md
# dct_row_packer

Input stage of the 2D DCT datapath. It accepts unsigned pixels one per handshake and applies a level shift (pixel − 2^(PW−1)), sign-extended to BW bits. It packs each group of 16 samples into one 16×BW row word and issues that row with a one-cycle enable to the row-transform stage, which feeds the 16×16 transpose memory. It tracks row position within a 16-row block and can insert a fixed idle gap between blocks so downstream stages can drain.

## Interface
- BW, 11, element width of packed output samples (two's complement); BW ≥ PW.
- PW, 8, input pixel width (unsigned).
- GAP, 0, idle cycles forced after each 16-row block (0 = no gap).

- i_clk  input  1  clock, all state updates on rising edge.
- i_Reset  input  1  synchronous, active-high reset.
- i_pixel  input  PW  unsigned pixel sample.
- i_valid  input  1  i_pixel valid this cycle.
- o_ready  output  1  block accepts a sample this cycle; accept = i_valid && o_ready.
- o_data  output  16*BW  packed row; sample 0 (first accepted) in [16*BW-1:15*BW], sample 15 in [BW-1:0].
- o_en  output  1  one-cycle pulse: o_data holds a new complete row.
- o_row  output  4  row index (0–15) of the row on o_data.
- o_last  output  1  high with o_en when o_row == 15.

## Operation
- Level shift: elem = {(BW−PW){~p[PW−1]}}, ~p[PW−1], p[PW−2:0]. This equals pixel − 2^(PW−1), sign-extended. No saturation is needed.
- Column counter col (0–15) increments on every accept. An accepted sample goes into packing register slot col.
- On the accept with col == 15:
  - The completed row, including the current sample, is loaded into o_data on that edge.
  - o_en = 1, o_row = row counter, o_last = (row == 15).
  - col wraps to 0 and row increments mod 16.
- Packing continues into the next row while o_data is held (double buffered). o_data changes only on a row completion or a reset.
- States:
  - FILL: o_ready = 1.
  - GAPWAIT: o_ready = 0. A down-counter loads GAP and decrements each cycle. At count 1 it returns to FILL.
- FILL → GAPWAIT on the accept that completes row 15, only when GAP > 0. With GAP = 0 the block stays in FILL permanently.
- i_valid while o_ready = 0: the sample is ignored. No state change.
- i_valid gaps inside a row: the counters hold. Output content is independent of the spacing between samples.
- Reset (any time, including mid-row or mid-gap):
  - Registers: col = 0, row = 0, state = FILL, o_data = 0, o_en = 0, o_row = 0, o_last = 0.
  - Any partial row is discarded without an o_en.
  - o_ready is forced 0 while i_Reset = 1, and is 1 on the first cycle after release.

## Timing
- Latency: o_en is high in the cycle after the edge that accepted the 16th sample of a row.
- o_en is never high for two consecutive cycles. The minimum spacing is 16 cycles between o_en rising edges with continuous i_valid.
- o_en, o_row, o_last and o_data are registered outputs. o_ready is combinational from state and i_Reset only, never from i_valid.
- GAP: o_ready is low for exactly GAP cycles, starting the cycle after the completing accept of row 15. The o_en/o_last pulse for row 15 coincides with the first gap cycle.
- Block throughput with continuous input: 256 + GAP cycles per 16×16 block.

## Test plan
- Reset: hold i_Reset 3 cycles with random i_valid/i_pixel.
  - During reset: o_ready = 0, o_en = 0, o_data = 0, o_row = 0, o_last = 0.
  - o_ready = 1 the cycle after release.
- Continuous row (BW=11, PW=8): pixels 0..15 on 16 consecutive cycles.
  - o_en high one cycle after the 16th sample.
  - o_data[175:165] = 11'h780 (pixel 0 → −128); o_data[10:0] = 11'h78F (pixel 15 → −113); o_row = 0; o_last = 0.
- Extremes and bubbles: row of 255, 128, 127, 0 repeated, with random i_valid holes.
  - Slices are 11'h07F, 11'h000, 11'h7FF, 11'h780 repeated.
  - Result matches the hole-free run; o_en occurs only once.
- Full block, GAP=16: 256 continuous samples.
  - 16 o_en pulses with o_row 0..15; o_last only on row 15.
  - o_ready low exactly 16 cycles after it; samples presented during the gap are not accepted.
  - The next accepted sample lands in row 0, slot 0.
- Mid-row reset: accept 7 samples, pulse i_Reset 1 cycle, then send 16 samples.
  - No o_en for the partial row.
  - First o_en carries only the 16 post-reset samples, with o_row = 0.
- Hold behaviour: after one row, idle i_valid = 0 for 50 cycles.
  - o_data stays unchanged and o_en stays 0.
